// File: rtl/uart_frame_rx.sv
// uart_frame_rx
//   Receives 8N1 serial frames and queues the bytes in a 4-entry
//   first-word-fall-through FIFO.
//
// Parameters
//   CLK_HZ : system clock frequency in Hz
//   BAUD   : serial bit rate; one bit lasts CLK_HZ/BAUD clocks
//
// Ports
//   clk_clk       in   system clock, all state changes on its rising edge
//   reset_reset_n in   synchronous active-low reset
//   uart_rxd      in   asynchronous serial line, idles high
//   rx_data       out  byte at the FIFO head (valid while rx_valid=1)
//   rx_valid      out  FIFO non-empty
//   rx_ready      in   consumer takes the head byte when rx_valid=1
//   frame_err     out  one-cycle pulse when a stop bit reads 0
//   overrun       out  one-cycle pulse when a good byte is dropped (FIFO full)
//   fifo_count    out  number of stored bytes, 0..4
module uart_frame_rx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic [2:0] fifo_count
);

  localparam int CBIT = CLK_HZ / BAUD;
  localparam int HALF = CBIT / 2;
  localparam int CW   = $clog2(CBIT + 1);
  localparam logic [CW-1:0] CBIT_M1 = CW'(CBIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Two-flop synchronizer; both flops reset to the idle (high) line level
  // so a reset never looks like a start bit.
  logic rxd_meta_q;
  logic rxd_s_q;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // Receiver FSM
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push;
  logic          frame_err_q, frame_err_d;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s_q) state_d = S_START;
      end
      S_START: begin
        // Re-check the line half a bit in; a high line means it was a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rxd_s_q) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        // Counting a full bit from mid-start lands each sample mid-bit.
        if (cnt_q == CBIT_M1) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CBIT_M1) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so it is not mistaken for new start bits.
        cnt_d = '0;
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // 4-entry FWFT FIFO
  logic [7:0] mem_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;
  logic       overrun_q, overrun_d;
  logic       pop, full, wr_en;

  assign pop   = (count_q != 3'd0) && rx_ready;
  assign full  = (count_q == 3'd4);
  // A pop in the same cycle frees the slot the push needs.
  assign wr_en = push && (!full || pop);
  assign overrun_d = push && full && !pop;
  assign count_d   = count_q + {2'b00, wr_en} - {2'b00, pop};

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= 8'h00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_data    = mem_q[rd_ptr_q];
  assign rx_valid   = (count_q != 3'd0);
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/uart_frame_rx.md
UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning the system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 SHALL define the derived constant CBIT = CLK_HZ/BAUD (integer division; 434 at defaults) and HALF = CBIT/2 (217 at defaults).
REQ-004 SHALL have port clk_clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_reset_n, input, 1 bit, synchronous active-low reset.
REQ-006 SHALL have port uart_rxd, input, 1 bit, asynchronous serial line carrying 8N1 frames; idles high.
REQ-007 SHALL have port rx_data, output, 8 bits, the byte at the FIFO head.
REQ-008 SHALL have port rx_valid, output, 1 bit, high when the FIFO is non-empty.
REQ-009 SHALL have port rx_ready, input, 1 bit, consumer accepts the head byte.
REQ-010 SHALL have port frame_err, output, 1 bit, one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun, output, 1 bit, one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-012 SHALL have port fifo_count, output, 3 bits, number of stored bytes, 0..4.

Function
REQ-013 SHALL pass uart_rxd through a 2-flop synchronizer (rxd_s); both flops load 1 on reset; all sampling uses rxd_s.
REQ-014 SHALL implement the states IDLE, START, DATA, STOP and BREAK with a bit-time counter and a 3-bit bit index.
REQ-015 IDLE: counter held at 0; rxd_s==0 -> START.
REQ-016 START: counter increments; at counter==HALF-1, rxd_s==0 -> DATA with counter=0 and index=0; rxd_s==1 -> IDLE with no error flagged (glitch rejection).
REQ-017 DATA: at counter==CBIT-1, SHALL sample rxd_s LSB-first into the shift register and reset counter=0; after the sample at index 7 -> STOP, otherwise increment the index.
REQ-018 STOP: at counter==CBIT-1, rxd_s==1 -> push the byte to the FIFO and go to IDLE; rxd_s==0 -> pulse frame_err, discard the byte and go to BREAK.
REQ-019 BREAK: SHALL remain until rxd_s==1, then go to IDLE; no bytes or errors are produced in BREAK.
REQ-020 FIFO SHALL be 4 entries deep, first-word-fall-through, with 2-bit read/write pointers that wrap 3->0.
REQ-021 rx_data SHALL equal the head entry whenever rx_valid=1; rx_data SHALL be don't-care, but stable, when the FIFO is empty.
REQ-022 A pop SHALL occur exactly when rx_valid && rx_ready; rx_ready while empty SHALL have no effect.
REQ-023 A pushed byte SHALL make rx_valid=1 on the cycle after the stop-bit sample edge (1-cycle latency).
REQ-024 Push to a full FIFO without a simultaneous pop SHALL drop the byte, pulse overrun for one cycle and leave the FIFO unchanged.
REQ-025 Simultaneous push and pop on a full FIFO SHALL perform both, keep fifo_count=4 and not pulse overrun.
REQ-026 Simultaneous push and pop on a FIFO holding 1..3 bytes SHALL leave fifo_count unchanged.
REQ-027 frame_err and overrun SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-028 With reset_reset_n low at a clock edge, the block SHALL enter IDLE, clear the counter, index, pointers and shift register, and drive rx_valid=0, fifo_count=0, frame_err=0, overrun=0, rx_data=8'h00.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no push and no error pulse; reception resumes at the next falling edge after release.

Verification
REQ-030 Defaults, rx_ready=1, send 0xA5 at 434 clk/bit -> rx_valid pulses once with rx_data=0xA5; frame_err=0, overrun=0.
REQ-031 Low glitch of 100 clk on an idle line -> state returns to IDLE; no rx_valid and no frame_err.
REQ-032 Frame 0x3C with stop bit 0, line held low 2000 clk then high, then 0x81 -> one frame_err pulse, no 0x3C push, then 0x81 received.
REQ-033 rx_ready=0, send 0x01..0x05 -> fifo_count reaches 4 and one overrun pulse at 0x05; then rx_ready=1 drains 0x01,0x02,0x03,0x04 in order.
REQ-034 FIFO full, rx_ready=1 on the exact cycle 0x77 is pushed -> fifo_count stays 4 with no overrun; 0x77 is read last.
REQ-035 Reset pulse during the data bits of 0x5A, then send 0xC3 -> only 0xC3 is received; fifo_count=1.
